cat_trap_board: RTL

- Parametrised N×N Cat Trap game core: game FSM, board occupancy storage, player cursor, one-step cat move policy, and win/loss detection.
- Includes a registered VGA pixel colourer.
- Sits between the debounced button pulses and the VGA sync generator, which supplies hCount, vCount and bright.
- Replaces the fixed 8×8, hard-coded-colour board.

---
 rtl/cat_trap_board.sv | 234 +++++++++++++++++++++++
 1 files changed

// File: rtl/cat_trap_board.sv
// Cat Trap game core: NxN board, cursor, one-step cat policy, win/loss detection and VGA colourer.
// Define RANDOM_BLOCKS_EN to add a SEED state that drops LFSR-chosen blocks before play.
module cat_trap_board #(
    parameter int unsigned N           = 8,
    parameter int unsigned ORIGIN_X    = 222,
    parameter int unsigned ORIGIN_Y    = 35,
    parameter int unsigned CELL        = 51,
    parameter int unsigned PITCH       = 60,
    parameter int unsigned RAND_BLOCKS = 6,
    localparam int unsigned CW         = $clog2(N)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          btn_up,
    input  logic          btn_down,
    input  logic          btn_left,
    input  logic          btn_right,
    input  logic          btn_center,
    input  logic [9:0]    hCount,
    input  logic [9:0]    vCount,
    input  logic          bright,
`ifdef RANDOM_BLOCKS_EN
    output logic [5:0]    state,
`else
    output logic [4:0]    state,
`endif
    output logic [CW-1:0] cat_row,
    output logic [CW-1:0] cat_col,
    output logic [CW-1:0] cur_row,
    output logic [CW-1:0] cur_col,
    output logic [7:0]    move_count,
    output logic [11:0]   rgb
);

    localparam int unsigned IW = $clog2(N * N);

`ifdef RANDOM_BLOCKS_EN
    localparam int unsigned SCW = $clog2(RAND_BLOCKS + 1);
    typedef enum logic [5:0] {
        S_START = 6'b000001,
        S_PLAY  = 6'b000010,
        S_MOVE  = 6'b000100,
        S_OVER  = 6'b001000,
        S_WIN   = 6'b010000,
        S_SEED  = 6'b100000
    } state_t;
`else
    typedef enum logic [4:0] {
        S_START = 5'b00001,
        S_PLAY  = 5'b00010,
        S_MOVE  = 5'b00100,
        S_OVER  = 5'b01000,
        S_WIN   = 5'b10000
    } state_t;
`endif

    state_t           st;
    logic [N*N-1:0]   blocked;

    function automatic logic [IW-1:0] idx(input logic [CW-1:0] r, input logic [CW-1:0] c);
        return IW'(r) * IW'(N) + IW'(c);
    endfunction

    assign state = st;

    // Cat neighbour evaluation, checked in order up, left, down, right
    logic [CW-1:0] rm1, rp1, cm1, cp1;
    logic          nb_up, nb_lt, nb_dn, nb_rt;
    logic [CW-1:0] nxt_row, nxt_col;
    logic          nxt_edge, place_ok;

    assign rm1   = cat_row - CW'(1);
    assign rp1   = cat_row + CW'(1);
    assign cm1   = cat_col - CW'(1);
    assign cp1   = cat_col + CW'(1);
    assign nb_up = (cat_row != '0) && !blocked[idx(rm1, cat_col)];
    assign nb_lt = (cat_col != '0) && !blocked[idx(cat_row, cm1)];
    assign nb_dn = (cat_row != CW'(N - 1)) && !blocked[idx(rp1, cat_col)];
    assign nb_rt = (cat_col != CW'(N - 1)) && !blocked[idx(cat_row, cp1)];

    always_comb begin
        nxt_row = cat_row;
        nxt_col = cat_col;
        if (nb_up)      nxt_row = rm1;
        else if (nb_lt) nxt_col = cm1;
        else if (nb_dn) nxt_row = rp1;
        else if (nb_rt) nxt_col = cp1;
    end

    assign nxt_edge = (nxt_row == '0) || (nxt_row == CW'(N - 1)) ||
                      (nxt_col == '0) || (nxt_col == CW'(N - 1));
    assign place_ok = !blocked[idx(cur_row, cur_col)] &&
                      !((cur_row == cat_row) && (cur_col == cat_col));

`ifdef RANDOM_BLOCKS_EN
    logic [15:0]    lfsr;
    logic [SCW-1:0] seed_cnt;
    logic [CW-1:0]  seed_row, seed_col;
    logic           seed_ok;

    assign seed_row = lfsr[CW-1:0];
    assign seed_col = lfsr[2*CW-1:CW];
    assign seed_ok  = ((CW+1)'(seed_row) < (CW+1)'(N)) && ((CW+1)'(seed_col) < (CW+1)'(N)) &&
                      !((seed_row == cat_row) && (seed_col == cat_col));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) lfsr <= 16'hACE1;
        else       lfsr <= lfsr[0] ? ((lfsr >> 1) ^ 16'hB400) : (lfsr >> 1);
    end
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            st         <= S_START;
            blocked    <= '0;
            cat_row    <= CW'(N / 2);
            cat_col    <= CW'(N / 2);
            cur_row    <= '0;
            cur_col    <= '0;
            move_count <= '0;
`ifdef RANDOM_BLOCKS_EN
            seed_cnt   <= '0;
`endif
        end else begin
            case (st)
                S_START: if (btn_center) begin
                    blocked    <= '0;
                    cat_row    <= CW'(N / 2);
                    cat_col    <= CW'(N / 2);
                    cur_row    <= '0;
                    cur_col    <= '0;
                    move_count <= '0;
`ifdef RANDOM_BLOCKS_EN
                    seed_cnt   <= '0;
                    st         <= S_SEED;
`else
                    st         <= S_PLAY;
`endif
                end
`ifdef RANDOM_BLOCKS_EN
                S_SEED: begin
                    if (seed_ok) blocked[idx(seed_row, seed_col)] <= 1'b1;
                    seed_cnt <= seed_cnt + SCW'(1);
                    if (seed_cnt == SCW'(RAND_BLOCKS - 1)) st <= S_PLAY;
                end
`endif
                S_PLAY: begin
                    if (btn_center) begin
                        if (place_ok) begin
                            blocked[idx(cur_row, cur_col)] <= 1'b1;
                            if (move_count != 8'hFF) move_count <= move_count + 8'd1;
                            st <= S_MOVE;
                        end
                    end else if (btn_up) begin
                        cur_row <= (cur_row == '0) ? CW'(N - 1) : cur_row - CW'(1);
                    end else if (btn_down) begin
                        cur_row <= (cur_row == CW'(N - 1)) ? '0 : cur_row + CW'(1);
                    end else if (btn_left) begin
                        cur_col <= (cur_col == '0) ? CW'(N - 1) : cur_col - CW'(1);
                    end else if (btn_right) begin
                        cur_col <= (cur_col == CW'(N - 1)) ? '0 : cur_col + CW'(1);
                    end
                end
                S_MOVE: begin
                    if (!(nb_up || nb_lt || nb_dn || nb_rt)) begin
                        st <= S_WIN;
                    end else begin
                        cat_row <= nxt_row;
                        cat_col <= nxt_col;
                        st      <= nxt_edge ? S_OVER : S_PLAY;
                    end
                end
                S_OVER, S_WIN: if (btn_center) st <= S_START;
                default: st <= S_START;
            endcase
        end
    end

    // Pixel-to-cell decode; PITCH > CELL so at most one row and one column hit
    logic          h_hit, v_hit;
    logic [CW-1:0] h_idx, v_idx;

    always_comb begin
        h_hit = 1'b0;
        v_hit = 1'b0;
        h_idx = '0;
        v_idx = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if ((32'(hCount) >= ORIGIN_X + i * PITCH) &&
                (32'(hCount) <= ORIGIN_X + i * PITCH + CELL - 1)) begin
                h_hit = 1'b1;
                h_idx = CW'(i);
            end
            if ((32'(vCount) >= ORIGIN_Y + i * PITCH) &&
                (32'(vCount) <= ORIGIN_Y + i * PITCH + CELL - 1)) begin
                v_hit = 1'b1;
                v_idx = CW'(i);
            end
        end
    end

    logic [11:0] bg_c, pix_c;

    always_comb begin
        case (st)
            S_START: bg_c = 12'h00F;
            S_OVER:  bg_c = 12'hF00;
            S_WIN:   bg_c = 12'h0F0;
`ifdef RANDOM_BLOCKS_EN
            S_SEED:  bg_c = 12'h00F;
`endif
            default: bg_c = 12'h000;
        endcase
        pix_c = bg_c;
        if (!bright)
            pix_c = 12'h000;
        else if (h_hit && v_hit) begin
            if ((v_idx == cat_row) && (h_idx == cat_col))
                pix_c = 12'hF80;
            else if (blocked[idx(v_idx, h_idx)])
                pix_c = 12'h888;
            else if ((st == S_PLAY) && (v_idx == cur_row) && (h_idx == cur_col))
                pix_c = 12'h0F0;
            else
                pix_c = 12'hFFF;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) rgb <= 12'h000;
        else       rgb <= pix_c;
    end

endmodule
